// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with mid-bit sampling; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_break,
    output logic                    uart_rx_perr,
    output logic                    uart_rx_busy
);

    localparam int BAUD_TICKS = CLK_HZ / BIT_RATE;
    localparam int HALF       = BAUD_TICKS / 2;
    localparam int CW         = $clog2(BAUD_TICKS + 1);
    localparam int BW         = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic                    rx_meta_q, rx_meta_d;
    logic                    rxs_q, rxs_d;
    logic [CW-1:0]           baud_cnt_q, baud_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    ferr_q, ferr_d;
    logic                    valid_q, valid_d;
    logic                    brk_q, brk_d;
    logic                    busy_q, busy_d;
    logic                    tick;
    logic                    stop_bad;
    logic                    par_bad;
`ifdef UART_RX_PARITY_EN
    logic                    par_q, par_d;
    logic                    perr_q, perr_d;
`endif

    // two-flop synchronizer for the asynchronous serial line
    always_comb begin
        rx_meta_d = uart_rxd;
        rxs_d     = rx_meta_q;
    end

    // all state registers; line synchronizer resets to idle-high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx_meta_d;
            rxs_q      <= rxs_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
            brk_q      <= brk_d;
            busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    // frame sequencing: baud countdown, bit capture, stop/parity checks, strobes
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;
        brk_d      = 1'b0;
        tick       = (baud_cnt_q == '0);
        stop_bad   = ferr_q | ~rxs_q;
        par_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
        par_bad    = (par_q != ^shreg_q);
`endif
        case (state_q)
            S_IDLE: begin
                if (uart_rx_en && !rxs_q) begin
                    state_d    = S_START;
                    baud_cnt_d = CW'(HALF - 1);
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rxs_q) begin
                        state_d    = S_DATA;
                        bit_cnt_d  = '0;
                        baud_cnt_d = CW'(BAUD_TICKS - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d    = {rxs_q, shreg_q[PAYLOAD_BITS-1:1]};
                    baud_cnt_d = CW'(BAUD_TICKS - 1);
                    if (bit_cnt_q == BW'(PAYLOAD_BITS - 1)) begin
                        bit_cnt_d = '0;
                        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_d      = rxs_q;
                    baud_cnt_d = CW'(BAUD_TICKS - 1);
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        // framing error outranks parity; IDLE re-entered at stop mid-point
                        if (stop_bad) begin
                            brk_d   = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                            perr_d  = 1'b1;
`endif
                            state_d = S_IDLE;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shreg_q;
                            state_d = S_IDLE;
                        end
                    end else begin
                        ferr_d     = stop_bad;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        baud_cnt_d = CW'(BAUD_TICKS - 1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign uart_rx_data  = data_q;
    assign uart_rx_valid = valid_q;
    assign uart_rx_break = brk_q;
    assign uart_rx_busy  = busy_q;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_perr  = perr_q;
`else
    assign uart_rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (table vectors, hand sequences, random frames)
module tb_uart_rx;

    localparam int BT   = 10;
    localparam int HALF = 5;
    localparam int NB   = 8;
    localparam int SB   = 1;
`ifdef UART_RX_PARITY_EN
    localparam int PB   = 1;
`else
    localparam int PB   = 0;
`endif
    localparam int LAT  = 2 + HALF + (NB + PB + SB) * BT + 1;

    localparam int K_VALID = 0;
    localparam int K_BREAK = 1;
    localparam int K_PERR  = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_break;
    logic       uart_rx_perr;
    logic       uart_rx_busy;

    uart_rx #(
        .CLK_HZ      (50_000_000),
        .BIT_RATE    (5_000_000),
        .PAYLOAD_BITS(NB),
        .STOP_BITS   (SB)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rxd     (uart_rxd),
        .uart_rx_en   (uart_rx_en),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_break(uart_rx_break),
        .uart_rx_perr (uart_rx_perr),
        .uart_rx_busy (uart_rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] d;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [7:0] p;
        bit         stop_ok;
        bit         par_bad;
        int         gap;
        int         kind;
        logic [7:0] d;
    } vec_t;
    vec_t vt[$];

    logic [7:0] good_data = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        tick(n);
    endtask

    // drives one frame; the line is left at the last stop-bit level
    task automatic send_frame(input logic [7:0] p, input bit stop_ok, input bit par_bad);
        uart_rxd = 1'b0;
        tick(BT);
        for (int i = 0; i < NB; i++) begin
            uart_rxd = p[i];
            tick(BT);
        end
        if (PB == 1) begin
            uart_rxd = (^p) ^ par_bad;
            tick(BT);
        end
        for (int i = 0; i < SB; i++) begin
            uart_rxd = stop_ok;
            tick(BT);
        end
    endtask

    // reference outcome of one frame from the frame rules
    task automatic model_frame(input logic [7:0] p, input bit stop_ok, input bit par_bad);
        int k;
        if (!stop_ok)                 k = K_BREAK;
        else if (par_bad && PB == 1)  k = K_PERR;
        else                          k = K_VALID;
        if (k == K_VALID) good_data = p;
        exp_q.push_back('{cyc + LAT, k, good_data});
    endtask

    // strobe monitor: every strobe must match the next expected event exactly
    always @(negedge clk) begin
        if (resetn && (uart_rx_valid || uart_rx_break || uart_rx_perr)) begin
            int   kind;
            ev_t  e;
            check("one_strobe", int'(uart_rx_valid) + int'(uart_rx_break) + int'(uart_rx_perr), 1);
            kind = uart_rx_valid ? K_VALID : (uart_rx_break ? K_BREAK : K_PERR);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got kind %0d data 0x%0h expected none at cycle %0d",
                         kind, uart_rx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", kind, e.kind);
                check("strobe_cycle", cyc, e.at);
                check("strobe_data", uart_rx_data, e.d);
                if (uart_rx_valid) check("busy_after_valid", uart_rx_busy, 0);
            end
        end
    end

    initial begin
        int s;
        logic [7:0] p;
        bit sok, pbad;
        vt.push_back('{8'hA5, 1'b1, 1'b0, 20, K_VALID, 8'hA5});
        vt.push_back('{8'h00, 1'b1, 1'b0,  0, K_VALID, 8'h00});
        vt.push_back('{8'hFF, 1'b1, 1'b0, 20, K_VALID, 8'hFF});
        vt.push_back('{8'h5A, 1'b0, 1'b0,  5, K_BREAK, 8'hFF});
        vt.push_back('{8'hC3, 1'b1, 1'b0, 10, K_VALID, 8'hC3});
`ifdef UART_RX_PARITY_EN
        vt.push_back('{8'h07, 1'b1, 1'b0, 10, K_VALID, 8'h07});
        vt.push_back('{8'h07, 1'b1, 1'b1, 10, K_PERR,  8'h07});
        vt.push_back('{8'h55, 1'b0, 1'b1, 10, K_BREAK, 8'h07});
`endif

        // reset state
        tick(3);
        check("rst_data",  uart_rx_data,  0);
        check("rst_valid", uart_rx_valid, 0);
        check("rst_break", uart_rx_break, 0);
        check("rst_perr",  uart_rx_perr,  0);
        check("rst_busy",  uart_rx_busy,  0);
        resetn = 1'b1;
        idle(5);

        // table vectors
        foreach (vt[i]) begin
            exp_q.push_back('{cyc + LAT, vt[i].kind, vt[i].d});
            if (vt[i].kind == K_VALID) good_data = vt[i].d;
            send_frame(vt[i].p, vt[i].stop_ok, vt[i].par_bad);
            idle(vt[i].gap);
        end
        idle(20);

        // short low glitch while idle: rejected at start-bit re-sample
        s = cyc;
        uart_rxd = 1'b0;
        tick(3);
        uart_rxd = 1'b1;
        tick(2);
        check("glitch_busy_hi", uart_rx_busy, 1);
        tick(7);
        check("glitch_busy_lo", uart_rx_busy, 0);
        check("glitch_data", uart_rx_data, good_data);
        idle(20);

        // bad stop bit then line held low: exactly one break, then a good frame
        model_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(300);
        check("hold_busy", uart_rx_busy, 1);
        check("hold_data", uart_rx_data, good_data);
        idle(20);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(20);

        // enable dropped mid-frame: frame still completes
        model_frame(8'h96, 1'b1, 1'b0);
        fork
            send_frame(8'h96, 1'b1, 1'b0);
            begin
                tick(30);
                uart_rx_en = 1'b0;
            end
        join
        idle(20);
        // disabled receiver ignores a whole frame
        send_frame(8'h77, 1'b1, 1'b0);
        idle(20);
        check("disabled_busy", uart_rx_busy, 0);
        uart_rx_en = 1'b1;
        idle(5);

        // reset mid-data of 0x5A
        p = 8'h5A;
        uart_rxd = 1'b0;
        tick(BT);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = p[i];
            tick(BT);
        end
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_data",  uart_rx_data,  0);
        check("mid_rst_busy",  uart_rx_busy,  0);
        check("mid_rst_valid", uart_rx_valid, 0);
        check("mid_rst_break", uart_rx_break, 0);
        uart_rxd = 1'b1;
        good_data = 8'h00;
        tick(3);
        resetn = 1'b1;
        idle(30);
        model_frame(8'h81, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(10);

        // randomized frames against the reference model
        for (int n = 0; n < 40; n++) begin
            p    = 8'($urandom);
            sok  = ($urandom_range(0, 7) != 0);
            pbad = (PB == 1) ? ($urandom_range(0, 4) == 0) : 1'b0;
            model_frame(p, sok, pbad);
            send_frame(p, sok, pbad);
            idle($urandom_range(sok ? 0 : 1, 12));
        end

        idle(LAT + 20);
        check("pending_events", exp_q.size(), 0);
        check("final_data", uart_rx_data, good_data);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
